// File: rtl/multi_phase_light_ctrl_if.sv
// rtl/multi_phase_light_ctrl_if.sv - demand and lamp bundle between sensors, controller and lamp drivers
interface multi_phase_light_ctrl_if #(
    parameter int N_PHASES = 4
) ();
    localparam int PW = $clog2(N_PHASES);

    logic [N_PHASES-1:0] req;
    logic [N_PHASES-1:0] green;
    logic [N_PHASES-1:0] yellow;
    logic [N_PHASES-1:0] red;
    logic [PW-1:0]       phase;
    logic [1:0]          state;

    modport master (
        output req,
        input  green, yellow, red, phase, state
    );

    modport slave (
        input  req,
        output green, yellow, red, phase, state
    );
endinterface

// File: rtl/multi_phase_light_ctrl.sv
// rtl/multi_phase_light_ctrl.sv - N-phase signal controller, round-robin service with gap-out/max-out
module multi_phase_light_ctrl #(
    parameter int N_PHASES  = 4,
    parameter int TW        = 8,
    parameter int MIN_GREEN = 6,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW    = 2,
    parameter int ALL_RED   = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    multi_phase_light_ctrl_if.slave  bus
);
    localparam int PW = $clog2(N_PHASES);

    localparam logic [1:0] S_GREEN  = 2'd0;
    localparam logic [1:0] S_YELLOW = 2'd1;
    localparam logic [1:0] S_ALLRED = 2'd2;

    localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);
    localparam logic [TW-1:0] MAX_LAST = TW'(MAX_GREEN - 1);
    localparam logic [TW-1:0] YEL_LAST = TW'(YELLOW - 1);
    localparam logic [TW-1:0] AR_LAST  = TW'(ALL_RED - 1);
    localparam logic [TW-1:0] T_SAT    = '1;
    localparam logic [N_PHASES-1:0] ONE = {{(N_PHASES-1){1'b0}}, 1'b1};
    localparam logic [PW:0] N_WIDE = (PW+1)'(N_PHASES);

    logic [1:0]          state_q, state_d;
    logic [PW-1:0]       cur_q, cur_d;
    logic [PW-1:0]       nxt_q, nxt_d;
    logic [TW-1:0]       timer_q, timer_d;

    logic [N_PHASES-1:0] comp;
    logic [PW:0]         idx;
    logic [PW-1:0]       pick;
    logic                exit_green;
    logic [N_PHASES-1:0] lit;
    logic [N_PHASES-1:0] g_lamp;
    logic [N_PHASES-1:0] y_lamp;

    // Scan offsets from farthest to nearest so the nearest waiting phase after cur wins.
    always_comb begin
        comp = bus.req & ~(ONE << cur_q);
        idx  = '0;
        pick = cur_q;
        for (int k = N_PHASES - 1; k >= 1; k--) begin
            idx = {1'b0, cur_q} + (PW+1)'(k);
            if (idx >= N_WIDE) begin
                idx = idx - N_WIDE;
            end
            if (comp[idx[PW-1:0]]) begin
                pick = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        exit_green = (timer_q >= MIN_LAST) && (comp != '0) &&
                     (!bus.req[cur_q] || (timer_q >= MAX_LAST));
        state_d = state_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        case (state_q)
            S_GREEN: begin
                if (exit_green) begin
                    state_d = S_YELLOW;
                    nxt_d   = pick;
                end
            end
            S_YELLOW: begin
                if (timer_q == YEL_LAST) begin
                    state_d = S_ALLRED;
                end
            end
            S_ALLRED: begin
                if (timer_q == AR_LAST) begin
                    state_d = S_GREEN;
                    cur_d   = nxt_q;
                end
            end
            default: state_d = S_GREEN;
        endcase
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (timer_q == T_SAT) begin
            timer_d = timer_q;
        end else begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_GREEN;
            cur_q   <= '0;
            nxt_q   <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        lit    = ONE << cur_q;
        g_lamp = (state_q == S_GREEN)  ? lit : '0;
        y_lamp = (state_q == S_YELLOW) ? lit : '0;
    end

    assign bus.green  = g_lamp;
    assign bus.yellow = y_lamp;
    assign bus.red    = ~(g_lamp | y_lamp);
    assign bus.phase  = cur_q;
    assign bus.state  = state_q;
endmodule

// File: tb/tb_multi_phase_light_ctrl.sv
// tb/tb_multi_phase_light_ctrl.sv - directed scenarios checked against a behavioural signal-timing model
module tb_multi_phase_light_ctrl;
    localparam int N   = 4;
    localparam int MIN = 6;
    localparam int MAX = 20;
    localparam int YEL = 2;
    localparam int AR  = 1;

    logic clk;
    logic reset_n;
    int   errors;
    int   checks;
    int   cyc;
    bit   check_en;

    multi_phase_light_ctrl_if #(.N_PHASES(N)) bus ();

    multi_phase_light_ctrl #(
        .N_PHASES(N), .TW(8), .MIN_GREEN(MIN), .MAX_GREEN(MAX), .YELLOW(YEL), .ALL_RED(AR)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: interval kind (0 green, 1 yellow, 2 all-red), served phase, green cycles so far,
    // clearance cycles still to run.
    int m_kind;
    int m_cur;
    int m_nxt;
    int m_green_done;
    int m_left;

    always @(posedge clk) begin
        logic [N-1:0] rq;
        logic [N-1:0] others;
        bit found;
        rq = bus.req;
        if (!reset_n) begin
            m_kind = 0; m_cur = 0; m_nxt = 0; m_green_done = 1; m_left = 0;
        end else if (m_kind == 0) begin
            others = rq;
            others[m_cur] = 1'b0;
            if (m_green_done >= MIN && others != 0 && (!rq[m_cur] || m_green_done >= MAX)) begin
                found = 0;
                for (int k = 1; k < N; k++) begin
                    if (!found && others[(m_cur + k) % N]) begin
                        m_nxt = (m_cur + k) % N;
                        found = 1;
                    end
                end
                m_kind = 1;
                m_left = YEL;
            end else begin
                m_green_done++;
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                if (m_kind == 1) begin
                    m_kind = 2;
                    m_left = AR;
                end else begin
                    m_kind = 0;
                    m_cur = m_nxt;
                    m_green_done = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eg, ey, er;
        if (check_en) begin
            eg = '0; ey = '0;
            if (m_kind == 0) eg[m_cur] = 1'b1;
            if (m_kind == 1) ey[m_cur] = 1'b1;
            for (int i = 0; i < N; i++) er[i] = !(eg[i] || ey[i]);
            checks++;
            if (bus.green !== eg || bus.yellow !== ey || bus.red !== er) begin
                errors++;
                $display("FAIL model_lamps t=%0t got g=%b y=%b r=%b want g=%b y=%b r=%b",
                         $time, bus.green, bus.yellow, bus.red, eg, ey, er);
            end
            checks++;
            if (bus.phase !== 2'(m_cur) || bus.state !== 2'(m_kind)) begin
                errors++;
                $display("FAIL model_phase_state t=%0t got phase=%0d state=%0d want phase=%0d state=%0d",
                         $time, bus.phase, bus.state, m_cur, m_kind);
            end
            checks++;
            if (((bus.green | bus.yellow | bus.red) !== 4'b1111) ||
                ((bus.green & bus.yellow) | (bus.green & bus.red) | (bus.yellow & bus.red)) !== 4'b0000) begin
                errors++;
                $display("FAIL one_lamp_per_phase t=%0t got g=%b y=%b r=%b want exactly one per phase",
                         $time, bus.green, bus.yellow, bus.red);
            end
        end
    end

    task automatic adv(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #2;
            cyc++;
        end
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        reset_n = 1'b0;
        bus.req = r;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        cyc = 0;
        check_en = 1'b1;
    endtask

    task automatic lit(input string nm, input int c, input logic [3:0] g, input logic [3:0] y,
                       input logic [3:0] r, input logic [1:0] st, input logic [1:0] ph);
        adv(c);
        @(negedge clk);
        checks++;
        if ({bus.green, bus.yellow, bus.red, bus.state, bus.phase} !== {g, y, r, st, ph}) begin
            errors++;
            $display("FAIL %s cycle %0d got g=%b y=%b r=%b st=%0d ph=%0d want g=%b y=%b r=%b st=%0d ph=%0d",
                     nm, c, bus.green, bus.yellow, bus.red, bus.state, bus.phase, g, y, r, st, ph);
        end
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; check_en = 1'b0;
        reset_n = 1'b0;
        bus.req = '0;

        do_reset(4'b0000);
        lit("idle_reset", 0, 4'b0001, 4'b0000, 4'b1110, 2'd0, 2'd0);
        lit("idle_hold", 199, 4'b0001, 4'b0000, 4'b1110, 2'd0, 2'd0);

        do_reset(4'b0100);
        lit("gap_last_green", 5, 4'b0001, 4'b0000, 4'b1110, 2'd0, 2'd0);
        lit("gap_yellow_a", 6, 4'b0000, 4'b0001, 4'b1110, 2'd1, 2'd0);
        lit("gap_yellow_b", 7, 4'b0000, 4'b0001, 4'b1110, 2'd1, 2'd0);
        lit("gap_allred", 8, 4'b0000, 4'b0000, 4'b1111, 2'd2, 2'd0);
        lit("gap_green2", 9, 4'b0100, 4'b0000, 4'b1011, 2'd0, 2'd2);

        do_reset(4'b0011);
        lit("max_last_green0", 19, 4'b0001, 4'b0000, 4'b1110, 2'd0, 2'd0);
        lit("max_yellow0", 20, 4'b0000, 4'b0001, 4'b1110, 2'd1, 2'd0);
        lit("max_allred", 22, 4'b0000, 4'b0000, 4'b1111, 2'd2, 2'd0);
        lit("max_green1", 23, 4'b0010, 4'b0000, 4'b1101, 2'd0, 2'd1);
        lit("max_last_green1", 42, 4'b0010, 4'b0000, 4'b1101, 2'd0, 2'd1);
        lit("max_yellow1", 43, 4'b0000, 4'b0010, 4'b1101, 2'd1, 2'd1);
        lit("max_back_to0", 46, 4'b0001, 4'b0000, 4'b1110, 2'd0, 2'd0);

        do_reset(4'b1000);
        lit("wrap_green3", 9, 4'b1000, 4'b0000, 4'b0111, 2'd0, 2'd3);
        bus.req = 4'b0101;
        lit("wrap_last_green3", 14, 4'b1000, 4'b0000, 4'b0111, 2'd0, 2'd3);
        lit("wrap_yellow3", 15, 4'b0000, 4'b1000, 4'b0111, 2'd1, 2'd3);
        lit("wrap_green0", 18, 4'b0001, 4'b0000, 4'b1110, 2'd0, 2'd0);
        lit("wrap_max_green0", 37, 4'b0001, 4'b0000, 4'b1110, 2'd0, 2'd0);
        lit("wrap_yellow0", 38, 4'b0000, 4'b0001, 4'b1110, 2'd1, 2'd0);
        lit("wrap_green2", 41, 4'b0100, 4'b0000, 4'b1011, 2'd0, 2'd2);

        do_reset(4'b0010);
        lit("latch_last_green", 5, 4'b0001, 4'b0000, 4'b1110, 2'd0, 2'd0);
        adv(6);
        bus.req = 4'b1000;
        lit("latch_yellow", 6, 4'b0000, 4'b0001, 4'b1110, 2'd1, 2'd0);
        lit("latch_green1", 9, 4'b0010, 4'b0000, 4'b1101, 2'd0, 2'd1);

        do_reset(4'b0100);
        lit("rst_yellow", 6, 4'b0000, 4'b0001, 4'b1110, 2'd1, 2'd0);
        reset_n = 1'b0;
        adv(7);
        reset_n = 1'b1;
        cyc = 0;
        lit("rst_after", 0, 4'b0001, 4'b0000, 4'b1110, 2'd0, 2'd0);
        lit("rst_min_hold", 5, 4'b0001, 4'b0000, 4'b1110, 2'd0, 2'd0);
        lit("rst_exit", 6, 4'b0000, 4'b0001, 4'b1110, 2'd1, 2'd0);
        adv(7);
        reset_n = 1'b0;
        #5;
        reset_n = 1'b1;
        lit("rst_glitch_ignored", 9, 4'b0100, 4'b0000, 4'b1011, 2'd0, 2'd2);

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
